mul_div_unit: RTL and testbench

- Iterative multiply/divide unit for the MIPS32 execute stage.
- Sits beside the single-cycle ALU and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO at parametrised width.
- One result bit per cycle, with a start/busy/done handshake and a flush input for pipeline cancellation.

---
 rtl/mdu_pkg.sv | 19 +
 rtl/mul_div_unit.sv | 196 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_pkg;

   localparam logic [2:0] MDU_MULT  = 3'b000;
   localparam logic [2:0] MDU_MULTU = 3'b001;
   localparam logic [2:0] MDU_DIV   = 3'b010;
   localparam logic [2:0] MDU_DIVU  = 3'b011;
   localparam logic [2:0] MDU_MTHI  = 3'b100;
   localparam logic [2:0] MDU_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } mdu_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// MIPS32 HI/LO owner: MULT/MULTU/DIV/DIVU one bit per cycle, MTHI/MTLO in one edge.
// Latency: o_done DATA_W+2 edges after the start edge (start edge counted), any operands.
// Backpressure: starts accepted only in IDLE (o_busy low); i_flush cancels an in-flight op.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [2:0]        i_op,
   input  logic              i_flush,
   input  logic [DATA_W-1:0] i_data_A,
   input  logic [DATA_W-1:0] i_data_B,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_div_zero,
   output logic [DATA_W-1:0] o_hi,
   output logic [DATA_W-1:0] o_lo
);

   mdu_state_t          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   // wh: upper partial product / partial remainder; wl: multiplier / quotient
   logic [DATA_W:0]     wh_q, wh_d;
   logic [DATA_W-1:0]   wl_q, wl_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic                is_div_q, is_div_d;
   logic                qneg_q, qneg_d;
   logic                rneg_q, rneg_d;
   logic                dz_q, dz_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                dzo_q, dzo_d;

   logic                op_signed;
   logic                a_neg, b_neg;
   logic [DATA_W-1:0]   a_mag, b_mag;
   logic [DATA_W:0]     add_x, add_y, add_s;
   logic                add_sub;
   logic [2*DATA_W-1:0] prod, prod_fix;
   logic [DATA_W-1:0]   quo_fix, rem_fix;

   // Operand magnitudes: only the signed ops take abs()
   assign op_signed = (i_op == MDU_MULT) || (i_op == MDU_DIV);
   assign a_neg     = op_signed & i_data_A[DATA_W-1];
   assign b_neg     = op_signed & i_data_B[DATA_W-1];
   assign a_mag     = a_neg ? -i_data_A : i_data_A;
   assign b_mag     = b_neg ? -i_data_B : i_data_B;

   // Single shared adder: add for shift-add multiply, subtract for restoring divide
   always_comb begin
      if (is_div_q) begin
         add_x   = {wh_q[DATA_W-1:0], wl_q[DATA_W-1]};
         add_y   = {1'b0, b_q};
         add_sub = 1'b1;
      end else begin
         add_x   = wh_q;
         add_y   = wl_q[0] ? {1'b0, b_q} : '0;
         add_sub = 1'b0;
      end
      add_s = add_x + (add_sub ? ~add_y : add_y) + {{DATA_W{1'b0}}, add_sub};
   end

   // Sign correction applied in FIX; divide-by-zero forces an all-ones quotient
   always_comb begin
      prod     = {wh_q[DATA_W-1:0], wl_q};
      prod_fix = qneg_q ? -prod : prod;
      quo_fix  = dz_q ? '1 : (qneg_q ? -wl_q : wl_q);
      rem_fix  = rneg_q ? -wh_q[DATA_W-1:0] : wh_q[DATA_W-1:0];
   end

   // Next-state logic for the IDLE/CALC/FIX sequencer and the HI/LO registers
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wh_d     = wh_q;
      wl_d     = wl_q;
      b_d      = b_q;
      is_div_d = is_div_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dzo_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start && !i_flush) begin
               case (i_op)
                  MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                     wh_d     = '0;
                     wl_d     = a_mag;
                     b_d      = b_mag;
                     is_div_d = i_op[1];
                     qneg_d   = a_neg ^ b_neg;
                     rneg_d   = a_neg;
                     dz_d     = i_op[1] && (i_data_B == '0);
                     cnt_d    = CNT_W'(DATA_W);
                     busy_d   = 1'b1;
                     state_d  = CALC;
                  end
                  MDU_MTHI: hi_d = i_data_A;
                  MDU_MTLO: lo_d = i_data_A;
                  default: ;
               endcase
            end
         end
         CALC: begin
            if (i_flush) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               if (is_div_q) begin
                  // restore on borrow, quotient bit is the inverted borrow
                  wh_d = add_s[DATA_W] ? add_x : add_s;
                  wl_d = {wl_q[DATA_W-2:0], ~add_s[DATA_W]};
               end else begin
                  // carry out of the add shifts down into the upper half
                  wh_d = {1'b0, add_s[DATA_W:1]};
                  wl_d = {add_s[0], wl_q[DATA_W-1:1]};
               end
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
         end
         FIX: begin
            busy_d  = 1'b0;
            state_d = IDLE;
            if (!i_flush) begin
               if (is_div_q) begin
                  hi_d  = rem_fix;
                  lo_d  = quo_fix;
                  dzo_d = dz_q;
               end else begin
                  hi_d = prod_fix[2*DATA_W-1:DATA_W];
                  lo_d = prod_fix[DATA_W-1:0];
               end
               done_d = 1'b1;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // All state and registered outputs; reset discards any operation in flight
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wh_q     <= '0;
         wl_q     <= '0;
         b_q      <= '0;
         is_div_q <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dzo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wh_q     <= wh_d;
         wl_q     <= wl_d;
         b_q      <= b_d;
         is_div_q <= is_div_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dzo_q    <= dzo_d;
      end
   end

   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_div_zero = dzo_q;
   assign o_hi       = hi_q;
   assign o_lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed cases plus random ops against an arithmetic model.
// Latency: checks o_done at exactly 34 edges from the start edge.
// Backpressure: checks starts/MTHI ignored while busy, flush and async reset aborts.
module tb_mul_div_unit;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_start = 1'b0;
   logic [2:0]  i_op = 3'b000;
   logic        i_flush = 1'b0;
   logic [31:0] i_data_A = '0;
   logic [31:0] i_data_B = '0;
   logic        o_busy, o_done, o_div_zero;
   logic [31:0] o_hi, o_lo;

   int total = 0;
   int bad = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   mul_div_unit #(.DATA_W(32)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op),
      .i_flush(i_flush), .i_data_A(i_data_A), .i_data_B(i_data_B),
      .o_busy(o_busy), .o_done(o_done), .o_div_zero(o_div_zero),
      .o_hi(o_hi), .o_lo(o_lo)
   );

   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Architectural reference: plain integer arithmetic on the MIPS rules
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dz);
      longint      ps;
      logic [63:0] pu;
      int          q, r;
      dz = 1'b0;
      hi = m_hi;
      lo = m_lo;
      case (op)
         3'd0: begin
            ps = longint'($signed(a)) * longint'($signed(b));
            pu = ps;
            hi = pu[63:32];
            lo = pu[31:0];
         end
         3'd1: begin
            pu = {32'b0, a} * {32'b0, b};
            hi = pu[63:32];
            lo = pu[31:0];
         end
         3'd2, 3'd3: begin
            if (b == 32'd0) begin
               dz = 1'b1;
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else if (op == 3'd3) begin
               lo = a / b;
               hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000;
               hi = 32'd0;
            end else begin
               q = $signed(a) / $signed(b);
               r = $signed(a) % $signed(b);
               lo = q;
               hi = r;
            end
         end
         default: ;
      endcase
   endtask

   // Arithmetic op: start, count edges to o_done, compare against the model
   task automatic do_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ehi, elo;
      logic        edz;
      int          n;
      logic        busy_ok;
      model(op, a, b, ehi, elo, edz);
      i_start = 1'b1; i_op = op; i_data_A = a; i_data_B = b;
      step();
      i_start = 1'b0;
      i_data_A = $urandom; i_data_B = $urandom;
      n = 1;
      busy_ok = 1'b1;
      while (o_done !== 1'b1 && n < 60) begin
         if (o_busy !== 1'b1 || o_hi !== m_hi || o_lo !== m_lo) busy_ok = 1'b0;
         step();
         n++;
      end
      chk({tag, ".latency"}, 64'(n), 64'd34);
      chk({tag, ".busy_hold"}, 64'(busy_ok), 64'd1);
      chk({tag, ".done_busy"}, 64'(o_busy), 64'd0);
      chk({tag, ".hi"}, 64'(o_hi), 64'(ehi));
      chk({tag, ".lo"}, 64'(o_lo), 64'(elo));
      chk({tag, ".dz"}, 64'(o_div_zero), 64'(edz));
      m_hi = ehi;
      m_lo = elo;
      step();
      chk({tag, ".done_pulse"}, 64'(o_done), 64'd0);
   endtask

   task automatic do_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
      i_start = 1'b1; i_op = op; i_data_A = a;
      step();
      i_start = 1'b0;
      if (op == 3'd4) m_hi = a;
      if (op == 3'd5) m_lo = a;
      chk({tag, ".hi"}, 64'(o_hi), 64'(m_hi));
      chk({tag, ".lo"}, 64'(o_lo), 64'(m_lo));
      chk({tag, ".busy_done"}, 64'({o_busy, o_done}), 64'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic seen_done;
      // reset state
      step(); step();
      chk("reset.out", 64'({o_busy, o_done, o_div_zero}), 64'd0);
      chk("reset.hilo", {o_hi, o_lo}, 64'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      step();

      // directed cases
      do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("multu_max.const", {o_hi, o_lo}, 64'hFFFF_FFFE_0000_0001);
      do_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5);
      chk("mult_neg.const", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      do_mt("mtlo", 3'd5, 32'h1234_5678);
      do_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
      chk("div_neg.const", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op("divu_small", 3'd3, 32'd7, 32'd2);
      do_op("divu_zero", 3'd3, 32'h64, 32'd0);
      do_op("div_zero_neg", 3'd2, 32'hFFFF_FF00, 32'd0);
      do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_ovf.const", {o_hi, o_lo}, 64'h0000_0000_8000_0000);

      // flush and ignored requests while busy
      do_mt("mthi_a", 3'd4, 32'hAAAA_0000);
      do_mt("mtlo_5", 3'd5, 32'h0000_5555);
      do_mt("noop6", 3'd6, 32'hDEAD_BEEF);
      i_start = 1'b1; i_op = 3'd0; i_data_A = 32'd3; i_data_B = 32'd4;
      step();                                    // edge 1
      i_start = 1'b0;
      step(); step();                            // edges 2,3
      i_start = 1'b1; i_op = 3'd4; i_data_A = 32'h0BAD_0BAD;
      step();                                    // edge 4: MTHI while busy
      i_op = 3'd1; i_data_A = 32'hFFFF_FFFF; i_data_B = 32'hFFFF_FFFF;
      step();                                    // edge 5: start while busy
      i_start = 1'b0;
      chk("busy_ign.hi", 64'(o_hi), 64'h0000_0000_AAAA_0000);
      for (int k = 6; k <= 10; k++) step();      // edges 6..10
      i_flush = 1'b1;
      step();                                    // edge 11
      i_flush = 1'b0;
      chk("flush.busy", 64'(o_busy), 64'd0);
      seen_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (o_done === 1'b1) seen_done = 1'b1;
         step();
      end
      chk("flush.no_done", 64'(seen_done), 64'd0);
      chk("flush.hilo", {o_hi, o_lo}, 64'hAAAA_0000_0000_5555);

      // flush together with start: nothing starts
      i_start = 1'b1; i_flush = 1'b1; i_op = 3'd1; i_data_A = 32'd9; i_data_B = 32'd9;
      step();
      i_start = 1'b0; i_flush = 1'b0;
      chk("flush_start.busy", 64'(o_busy), 64'd0);
      // flush alone in IDLE, then a normal op still works
      i_flush = 1'b1;
      step();
      i_flush = 1'b0;
      do_op("after_flush", 3'd1, 32'd3, 32'd4);

      // random ops against the model
      for (int t = 0; t < 24; t++) begin
         int op;
         op = $urandom_range(0, 9);
         if (op <= 3) do_op("rand", 3'(op), pick(), pick());
         else if (op <= 7) do_mt("rand_mt", 3'($urandom_range(4, 7)), $urandom);
         else do_op("rand_div", 3'($urandom_range(2, 3)), $urandom, 32'($urandom_range(1, 300)));
      end

      // asynchronous reset mid-divide
      i_start = 1'b1; i_op = 3'd2; i_data_A = 32'd1000; i_data_B = 32'd7;
      step();
      i_start = 1'b0;
      for (int k = 0; k < 8; k++) step();
      #2 i_rst = 1'b1;
      #1;
      chk("arst.out", 64'({o_busy, o_done, o_div_zero}), 64'd0);
      chk("arst.hilo", {o_hi, o_lo}, 64'd0);
      m_hi = '0;
      m_lo = '0;
      @(negedge i_clk);
      i_rst = 1'b0;
      step();
      do_op("post_rst", 3'd1, 32'd2, 32'd3);
      chk("post_rst.const", {o_hi, o_lo}, 64'd6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
